// File: rtl/lifo_stack_pkg.sv
// lifo_stack shared types: command encoding and size helpers.
// Build option: LIFO_STACK_ERR_FLAGS_EN adds sticky overflow/underflow.
package lifo_stack_pkg;

  typedef enum logic [1:0] {
    NOP     = 2'b00,
    POP     = 2'b01,
    PUSH    = 2'b10,
    REPLACE = 2'b11
  } cmd_e;

  function automatic int calc_aw(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int calc_iw(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic cmd_e decode_cmd(
    input logic en,
    input logic push,
    input logic pop
  );
    return en ? cmd_e'({push, pop}) : NOP;
  endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// lifo_stack command/status bundle between controller and stack.
// Build option: LIFO_STACK_ERR_FLAGS_EN adds overflow/underflow.
interface lifo_stack_if
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = calc_aw(DEPTH);

  logic             en;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             pop_valid;
  logic [WIDTH-1:0] top;
  logic [AW-1:0]    count;
  logic             full;
  logic             empty;
`ifdef LIFO_STACK_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

  modport master (
    output en, push, pop, data_in,
    input  data_out, pop_valid, top,
    input  count, full, empty
`ifdef LIFO_STACK_ERR_FLAGS_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  en, push, pop, data_in,
    output data_out, pop_valid, top,
    output count, full, empty
`ifdef LIFO_STACK_ERR_FLAGS_EN
    , output overflow, underflow
`endif
  );

endinterface

// File: rtl/lifo_stack_mem.sv
// lifo_stack storage: DEPTH x WIDTH array, sync write, async read.
// Contents are never reset; empty-stack reads are masked upstream.
module lifo_stack_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int IW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write port: one entry per cycle
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// lifo_stack top: command decode, occupancy count, output registers.
// Build option: LIFO_STACK_ERR_FLAGS_EN adds sticky overflow/underflow.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        clr,
  lifo_stack_if.slave bus
);

  localparam int AW = calc_aw(DEPTH);
  localparam int IW = calc_iw(DEPTH);

  cmd_e             cmd;
  logic [AW-1:0]    count_q;
  logic [WIDTH-1:0] dout_q;
  logic             pv_q;
  logic             is_empty;
  logic             is_full;
  logic             we;
  logic [IW-1:0]    waddr;
  logic [IW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;

  assign cmd      = decode_cmd(bus.en, bus.push, bus.pop);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == AW'(DEPTH));
  // top slot; clamped to 0 when empty so the read stays in range
  assign raddr    = is_empty ? '0 : IW'(count_q - AW'(1));

  // write-port control: push fills next slot, replace overwrites top
  always_comb begin
    we    = 1'b0;
    waddr = IW'(count_q);
    unique case (cmd)
      PUSH: begin
        we    = !is_full;
        waddr = IW'(count_q);
      end
      REPLACE: begin
        we    = !is_empty;
        waddr = raddr;
      end
      default: ;
    endcase
  end

  lifo_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.data_in),
    .raddr (raddr),
    .rdata (rdata)
  );

  // occupancy and pop result; guards keep count in 0..DEPTH
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count_q <= '0;
      dout_q  <= '0;
      pv_q    <= 1'b0;
    end else begin
      pv_q <= 1'b0;
      unique case (cmd)
        PUSH: begin
          if (!is_full) count_q <= count_q + AW'(1);
        end
        POP: begin
          if (!is_empty) begin
            count_q <= count_q - AW'(1);
            dout_q  <= rdata;
            pv_q    <= 1'b1;
          end
        end
        REPLACE: begin
          dout_q <= is_empty ? bus.data_in : rdata;
          pv_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef LIFO_STACK_ERR_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  // sticky error flags for dropped push / dropped pop
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (cmd == PUSH && is_full)  ovf_q <= 1'b1;
      if (cmd == POP  && is_empty) unf_q <= 1'b1;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`endif

  assign bus.data_out  = dout_q;
  assign bus.pop_valid = pv_q;
  assign bus.top       = is_empty ? '0 : rdata;
  assign bus.count     = count_q;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;

endmodule

// File: tb/tb_lifo_stack.sv
// lifo_stack bench: 8x4 and 16x5 instances, array model, literals.
// Honours LIFO_STACK_ERR_FLAGS_EN for the optional flag checks.
module tb_lifo_stack;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       en;
  logic       push;
  logic       pop;
  logic [7:0] d8;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  lifo_stack_if #(.WIDTH(8),  .DEPTH(4)) ia ();
  lifo_stack_if #(.WIDTH(16), .DEPTH(5)) ib ();

  assign ia.en      = en;
  assign ia.push    = push;
  assign ia.pop     = pop;
  assign ia.data_in = d8;
  assign ib.en      = en;
  assign ib.push    = push;
  assign ib.pop     = pop;
  assign ib.data_in = {~d8, d8};

  lifo_stack #(.WIDTH(8), .DEPTH(4)) dut_a (
    .clk (clk),
    .clr (clr),
    .bus (ia.slave)
  );

  lifo_stack #(.WIDTH(16), .DEPTH(5)) dut_b (
    .clk (clk),
    .clr (clr),
    .bus (ib.slave)
  );

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // model: plain array stack per instance (0 = 8x4, 1 = 16x5)
  int          dep [2] = '{4, 5};
  int          mcnt [2];
  logic [15:0] mmem [2][8];
  logic [15:0] mdo [2];
  bit          mpv [2];
  bit          movf [2];
  bit          mund [2];

  function automatic logic [15:0] dv(input int i);
    return (i == 0) ? {8'h00, d8} : {~d8, d8};
  endfunction

  function automatic logic [15:0] mtop(input int i);
    return (mcnt[i] == 0) ? 16'h0 : mmem[i][mcnt[i]-1];
  endfunction

  always @(posedge clk or negedge clr) begin
    for (int i = 0; i < 2; i++) begin
      if (!clr) begin
        mcnt[i] <= 0;
        mdo[i]  <= '0;
        mpv[i]  <= 1'b0;
        movf[i] <= 1'b0;
        mund[i] <= 1'b0;
      end else begin
        mpv[i] <= 1'b0;
        if (en) begin
          case ({push, pop})
            2'b10: begin
              if (mcnt[i] < dep[i]) begin
                mmem[i][mcnt[i]] <= dv(i);
                mcnt[i] <= mcnt[i] + 1;
              end else movf[i] <= 1'b1;
            end
            2'b01: begin
              if (mcnt[i] > 0) begin
                mdo[i]  <= mmem[i][mcnt[i]-1];
                mcnt[i] <= mcnt[i] - 1;
                mpv[i]  <= 1'b1;
              end else mund[i] <= 1'b1;
            end
            2'b11: begin
              mpv[i] <= 1'b1;
              if (mcnt[i] > 0) begin
                mdo[i] <= mmem[i][mcnt[i]-1];
                mmem[i][mcnt[i]-1] <= dv(i);
              end else mdo[i] <= dv(i);
            end
            default: ;
          endcase
        end
      end
    end
  end

  // compare both instances against the model every cycle
  always @(negedge clk) begin
    chk("a_count", 16'(ia.count), 16'(mcnt[0]));
    chk("a_full", 16'(ia.full), 16'(mcnt[0] == dep[0]));
    chk("a_empty", 16'(ia.empty), 16'(mcnt[0] == 0));
    chk("a_top", 16'(ia.top), mtop(0));
    chk("a_dout", 16'(ia.data_out), mdo[0]);
    chk("a_pv", 16'(ia.pop_valid), 16'(mpv[0]));
    chk("b_count", 16'(ib.count), 16'(mcnt[1]));
    chk("b_full", 16'(ib.full), 16'(mcnt[1] == dep[1]));
    chk("b_empty", 16'(ib.empty), 16'(mcnt[1] == 0));
    chk("b_top", ib.top, mtop(1));
    chk("b_dout", ib.data_out, mdo[1]);
    chk("b_pv", 16'(ib.pop_valid), 16'(mpv[1]));
`ifdef LIFO_STACK_ERR_FLAGS_EN
    chk("a_ovf", 16'(ia.overflow), 16'(movf[0]));
    chk("a_unf", 16'(ia.underflow), 16'(mund[0]));
    chk("b_ovf", 16'(ib.overflow), 16'(movf[1]));
    chk("b_unf", 16'(ib.underflow), 16'(mund[1]));
`endif
  end

  task automatic step(input logic e, input logic pu, input logic po,
                      input logic [7:0] d);
    en   = e;
    push = pu;
    pop  = po;
    d8   = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] pv [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    en   = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    d8   = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_count", 16'(ia.count), 16'd0);
    chk("rst_empty", 16'(ia.empty), 16'd1);
    chk("rst_full", 16'(ia.full), 16'd0);
    chk("rst_dout", 16'(ia.data_out), 16'd0);
    chk("rst_pv", 16'(ia.pop_valid), 16'd0);
    clr = 1'b1;

    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b0, pv[k]);
      chk("fill_count", 16'(ia.count), 16'(k + 1));
    end
    chk("fill_full", 16'(ia.full), 16'd1);
    chk("fill_top", 16'(ia.top), 16'h44);

    step(1'b1, 1'b1, 1'b0, 8'h55);
    chk("ovf_count", 16'(ia.count), 16'd4);
    chk("ovf_top", 16'(ia.top), 16'h44);
    chk("b5_count", 16'(ib.count), 16'd5);
    chk("b5_full", 16'(ib.full), 16'd1);
`ifdef LIFO_STACK_ERR_FLAGS_EN
    chk("ovf_flag", 16'(ia.overflow), 16'd1);
    chk("b_ovf_clr", 16'(ib.overflow), 16'd0);
`endif

    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("pop_dout", 16'(ia.data_out), 16'(pv[3-k]));
      chk("pop_pv", 16'(ia.pop_valid), 16'd1);
      if (k == 0) chk("b_pop_dout", ib.data_out, 16'hAA55);
    end
    chk("pop_empty", 16'(ia.empty), 16'd1);

    step(1'b1, 1'b0, 1'b1, 8'h00);
    chk("unf_pv", 16'(ia.pop_valid), 16'd0);
    chk("unf_dout", 16'(ia.data_out), 16'h11);
    chk("b_last_dout", ib.data_out, 16'hEE11);
    chk("b_last_empty", 16'(ib.empty), 16'd1);
`ifdef LIFO_STACK_ERR_FLAGS_EN
    chk("unf_flag", 16'(ia.underflow), 16'd1);
`endif
    step(1'b1, 1'b0, 1'b1, 8'h00);
    chk("b_unf_pv", 16'(ib.pop_valid), 16'd0);

    step(1'b1, 1'b1, 1'b0, 8'hA1);
    step(1'b1, 1'b1, 1'b0, 8'hB2);
    step(1'b1, 1'b1, 1'b1, 8'hC3);
    chk("rep_dout", 16'(ia.data_out), 16'hB2);
    chk("rep_pv", 16'(ia.pop_valid), 16'd1);
    chk("rep_count", 16'(ia.count), 16'd2);
    chk("rep_top", 16'(ia.top), 16'hC3);
    chk("b_rep_dout", ib.data_out, 16'h4DB2);
    chk("b_rep_top", ib.top, 16'h3CC3);

    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h5A);
    chk("byp_dout", 16'(ia.data_out), 16'h5A);
    chk("byp_pv", 16'(ia.pop_valid), 16'd1);
    chk("byp_count", 16'(ia.count), 16'd0);
    chk("byp_empty", 16'(ia.empty), 16'd1);
    chk("byp_top", 16'(ia.top), 16'h0);

    step(1'b0, 1'b1, 1'b0, 8'h77);
    chk("en0_count", 16'(ia.count), 16'd0);
    chk("en0_pv", 16'(ia.pop_valid), 16'd0);

    step(1'b1, 1'b1, 1'b0, 8'h01);
    step(1'b1, 1'b1, 1'b0, 8'h02);
    step(1'b1, 1'b1, 1'b0, 8'h03);
    chk("pre_clr_count", 16'(ia.count), 16'd3);
    d8 = 8'h04;
    #2 clr = 1'b0;
    #1;
    chk("aclr_count", 16'(ia.count), 16'd0);
    chk("aclr_dout", 16'(ia.data_out), 16'd0);
    chk("aclr_pv", 16'(ia.pop_valid), 16'd0);
    chk("aclr_empty", 16'(ia.empty), 16'd1);
    chk("aclr_b_count", 16'(ib.count), 16'd0);
`ifdef LIFO_STACK_ERR_FLAGS_EN
    chk("aclr_ovf", 16'(ia.overflow), 16'd0);
    chk("aclr_unf", 16'(ia.underflow), 16'd0);
`endif
    @(negedge clk);
    clr = 1'b1;
    step(1'b1, 1'b1, 1'b0, 8'h04);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    chk("post_dout", 16'(ia.data_out), 16'h04);
    chk("post_pv", 16'(ia.pop_valid), 16'd1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parametrised last-in/first-out buffer for the accumulator datapath, the next-generation operand/return stack. It adds configurable width and depth, simultaneous push/pop (replace-top), a combinational top-of-stack peek, an occupancy count, exported full/empty status, and a pop-valid strobe. It sits between the controller and the accumulator/ALU, and is driven by controller-issued push/pop commands.

## Interface
- WIDTH, 8, data width in bits
- DEPTH, 4, number of entries; any integer ≥ 2, not restricted to powers of two
- AW, derived localparam $clog2(DEPTH+1), width of `count`

- clk  input  1  clock; all state updates on the rising edge
- clr  input  1  asynchronous active-low reset; one clock, reset asserted asynchronously, released on the clock domain
- en  input  1  command enable; when 0, push and pop are ignored
- push  input  1  push request
- pop  input  1  pop request
- data_in  input  WIDTH  data to push
- data_out  output  WIDTH  registered value of the last pop; holds between pops
- pop_valid  output  1  one-cycle pulse, high in the cycle after a successful pop
- top  output  WIDTH  combinational peek at mem[count-1]; 0 when empty
- count  output  AW  current number of entries
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow, underflow  output  1 each  sticky error flags; present only under the macro in Configuration

## Operation
- Reset (clr=0), asynchronous:
  - count=0, empty=1, full=0.
  - data_out=0, pop_valid=0, overflow=0, underflow=0.
  - Memory contents are not cleared; they are unobservable because `top` is forced to 0 when empty.
- Command decode, applied only when en=1 (en=0 behaves as NOP):
  - NOP: no push, no pop. pop_valid=0.
  - PUSH (push=1, pop=0):
    - If not full: mem[count] <= data_in; count+1.
    - If full: command dropped; no state changes; overflow set.
  - POP (push=0, pop=1):
    - If not empty: data_out <= mem[count-1]; count-1; pop_valid=1.
    - If empty: command dropped; data_out holds; underflow set.
  - REPLACE (push=1, pop=1):
    - If not empty: data_out <= mem[count-1]; mem[count-1] <= data_in; count unchanged; pop_valid=1. Legal when full.
    - If empty: bypass. data_out <= data_in; pop_valid=1; count stays 0; nothing is written.
- full and empty are decoded from count; no separate state is stored.
- count arithmetic is unsigned AW bits. It never wraps, because guards block increment at DEPTH and decrement at 0.

## Timing
- Every command takes effect at the rising edge where en=1 is sampled.
- count, full, empty and top reflect the new state immediately after that edge.
- data_out and pop_valid update on the same edge, giving 1-cycle latency from pop request to data.
- pop_valid is high for exactly one cycle per accepted pop or replace. Back-to-back pops produce consecutive pulses.
- Push on the cycle after a pop writes the slot just vacated.
- clr asserted mid-operation aborts the command in flight; outputs take reset values immediately, without waiting for a clock edge.
- First accepted command after release is the first edge with clr=1.

## Configuration
- LIFO_STACK_ERR_FLAGS_EN defined:
  - overflow and underflow ports and logic exist.
  - Each flag is set on a dropped PUSH or dropped POP respectively.
  - Flags are sticky until clr.
- Undefined: both ports are absent; dropped commands are silent. All other behaviour is identical.

## Structure
- Package lifo_stack_pkg holds:
  - The 2-bit command enum {NOP, PUSH, POP, REPLACE}, decoded from {push, pop} gated by en.
  - A function computing AW from DEPTH.
- Sub-module lifo_stack_mem: DEPTH×WIDTH register array with one synchronous write port and one asynchronous read port (address count-1).
  - Not reset.
  - Top level holds count, the output registers and the decode logic.

## Test plan
- Reset, then push 0x11, 0x22, 0x33, 0x44 with DEPTH=4:
  - count 1→4, full=1 after the 4th push, top=0x44.
  - 5th push of 0x55 is dropped; overflow=1; top stays 0x44.
- From full, 4 pops:
  - data_out 0x44, 0x33, 0x22, 0x11 on successive cycles; pop_valid high 4 cycles; empty=1.
  - 5th pop: pop_valid=0, data_out holds 0x11, underflow=1.
- Stack holds 0xA1, 0xB2; push=pop=1 with data_in 0xC3:
  - data_out=0xB2, pop_valid=1, count=2, top=0xC3.
- Empty stack; push=pop=1 with data_in 0x5A:
  - data_out=0x5A, pop_valid=1, count=0, empty=1, top=0.
- Push 0x77 with en=0: no change (count=0).
- Then push 3 items and assert clr asynchronously between edges:
  - count=0, data_out=0, flags=0 before the next edge.
- Rerun the first and second scenarios with WIDTH=16, DEPTH=5, and with the macro undefined:
  - identical data behaviour; no error ports.
